// File: rtl/sap_control_sequencer_if.sv
// Bus between the SAP-U sequencer and the rest of the datapath: the
// IR/flag inputs it decodes and every load/enable strobe it drives.
interface sap_control_sequencer_if #(
  parameter int STEP_W = 3,
  parameter int OPC_W  = 4
);
  // No valid/ready pairs here: start and step_pulse are levels sampled on
  // each rising clk, and every strobe is valid for the whole cycle it is high.
  logic              start;
  logic [OPC_W-1:0]  opcode;
  logic              carry_flag;
  logic              zero_flag;
  logic              step_pulse;

  logic              pc_out;
  logic              ir_out;
  logic              ram_out;
  logic              a_out;
  logic              alu_out;
  logic              mar_load;
  logic              ir_load;
  logic              a_load;
  logic              b_load;
  logic              ram_load;
  logic              out_load;
  logic              pc_load;
  logic              flag_load;
  logic              pc_inc;
  logic              alu_sub;
  logic              halted;
  logic [STEP_W-1:0] step;
  logic [1:0]        dbg_state;

  modport master (
    output start, opcode, carry_flag, zero_flag, step_pulse,
    input  pc_out, ir_out, ram_out, a_out, alu_out,
    input  mar_load, ir_load, a_load, b_load, ram_load, out_load, pc_load,
    input  flag_load, pc_inc, alu_sub, halted, step, dbg_state
  );

  modport slave (
    input  start, opcode, carry_flag, zero_flag, step_pulse,
    output pc_out, ir_out, ram_out, a_out, alu_out,
    output mar_load, ir_load, a_load, b_load, ram_load, out_load, pc_load,
    output flag_load, pc_inc, alu_sub, halted, step, dbg_state
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-U microcode sequencer: T-state counter plus opcode/flag decode into strobes.
// Optional macro SAP_SEQ_SINGLE_STEP_EN: advance only on step_pulse, gate loads with it.
module sap_control_sequencer #(
  parameter int STEP_W = 3,
  parameter int OPC_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  sap_control_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] last_step;
  logic              advance;
  logic              ld_en;

  logic pc_out_c, ir_out_c, ram_out_c, a_out_c, alu_out_c;
  logic mar_load_c, ir_load_c, a_load_c, b_load_c, ram_load_c, out_load_c;
  logic pc_load_c, flag_load_c, pc_inc_c, alu_sub_c;

`ifdef SAP_SEQ_SINGLE_STEP_EN
  assign advance = bus.step_pulse;
  assign ld_en   = bus.step_pulse;
`else
  logic unused_step_pulse;
  assign unused_step_pulse = bus.step_pulse;
  assign advance = 1'b1;
  assign ld_en   = 1'b1;
`endif

  always_comb begin
    last_step = T2;
    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) last_step = T4;
    else if (bus.opcode == OP_LDA || bus.opcode == OP_STA) last_step = T3;
  end

  // Reset wins over start; the >= guard pulls an out-of-range step back to T0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= T0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          step_q <= T0;
          if (bus.start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (advance) begin
            if (step_q >= last_step) begin
              step_q <= T0;
              if (step_q == T2 && bus.opcode == OP_HLT) state_q <= ST_HALTED;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= T0;
        end
      endcase
    end
  end

  always_comb begin
    pc_out_c    = 1'b0;
    ir_out_c    = 1'b0;
    ram_out_c   = 1'b0;
    a_out_c     = 1'b0;
    alu_out_c   = 1'b0;
    mar_load_c  = 1'b0;
    ir_load_c   = 1'b0;
    a_load_c    = 1'b0;
    b_load_c    = 1'b0;
    ram_load_c  = 1'b0;
    out_load_c  = 1'b0;
    pc_load_c   = 1'b0;
    flag_load_c = 1'b0;
    pc_inc_c    = 1'b0;
    alu_sub_c   = 1'b0;
    if (state_q == ST_RUN) begin
      case (step_q)
        T0: begin pc_out_c = 1'b1; mar_load_c = 1'b1; end
        T1: begin ram_out_c = 1'b1; ir_load_c = 1'b1; pc_inc_c = 1'b1; end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out_c = 1'b1; mar_load_c = 1'b1; end
            OP_LDI: begin ir_out_c = 1'b1; a_load_c = 1'b1; end
            OP_JMP: begin ir_out_c = 1'b1; pc_load_c = 1'b1; end
            OP_JC:  begin ir_out_c = bus.carry_flag; pc_load_c = bus.carry_flag; end
            OP_JZ:  begin ir_out_c = bus.zero_flag;  pc_load_c = bus.zero_flag;  end
            OP_OUT: begin a_out_c = 1'b1; out_load_c = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin ram_out_c = 1'b1; a_load_c = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out_c = 1'b1; b_load_c = 1'b1; end
            OP_STA: begin a_out_c = 1'b1; ram_load_c = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            alu_out_c   = 1'b1;
            a_load_c    = 1'b1;
            flag_load_c = 1'b1;
            alu_sub_c   = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // Bus enables and alu_sub hold while waiting; only loads/inc are gated.
  assign bus.pc_out    = pc_out_c;
  assign bus.ir_out    = ir_out_c;
  assign bus.ram_out   = ram_out_c;
  assign bus.a_out     = a_out_c;
  assign bus.alu_out   = alu_out_c;
  assign bus.alu_sub   = alu_sub_c;
  assign bus.mar_load  = mar_load_c  & ld_en;
  assign bus.ir_load   = ir_load_c   & ld_en;
  assign bus.a_load    = a_load_c    & ld_en;
  assign bus.b_load    = b_load_c    & ld_en;
  assign bus.ram_load  = ram_load_c  & ld_en;
  assign bus.out_load  = out_load_c  & ld_en;
  assign bus.pc_load   = pc_load_c   & ld_en;
  assign bus.flag_load = flag_load_c & ld_en;
  assign bus.pc_inc    = pc_inc_c    & ld_en;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.step      = step_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: instruction table plus
// hand-written reset/halt/single-step sequences, checked through an expected queue.
module tb_sap_control_sequencer;

  localparam int W = 19;  // {halted, step[2:0], 15 strobes}

  localparam logic [14:0] PC_OUT  = 15'h4000;
  localparam logic [14:0] IR_OUT  = 15'h2000;
  localparam logic [14:0] RAM_OUT = 15'h1000;
  localparam logic [14:0] A_OUT   = 15'h0800;
  localparam logic [14:0] ALU_OUT = 15'h0400;
  localparam logic [14:0] MAR_LD  = 15'h0200;
  localparam logic [14:0] IR_LD   = 15'h0100;
  localparam logic [14:0] A_LD    = 15'h0080;
  localparam logic [14:0] B_LD    = 15'h0040;
  localparam logic [14:0] RAM_LD  = 15'h0020;
  localparam logic [14:0] OUT_LD  = 15'h0010;
  localparam logic [14:0] PC_LD   = 15'h0008;
  localparam logic [14:0] FLAG_LD = 15'h0004;
  localparam logic [14:0] PC_INC  = 15'h0002;
  localparam logic [14:0] ALU_SUB = 15'h0001;

  localparam logic [14:0] F0 = PC_OUT | MAR_LD;
  localparam logic [14:0] F1 = RAM_OUT | IR_LD | PC_INC;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  typedef struct {
    logic [3:0]  opc;
    logic        c;
    logic        z;
    int          n;
    logic [14:0] s2;
    logic [14:0] s3;
    logic [14:0] s4;
  } vec_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  bit   done;
  bit   manual_pulse;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_st_q[$];
  vec_t         tbl[$];

  sap_control_sequencer_if #(.STEP_W(3), .OPC_W(4)) bus ();

  sap_control_sequencer #(.STEP_W(3), .OPC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] act_w;
  assign act_w = {bus.halted, bus.step,
                  bus.pc_out, bus.ir_out, bus.ram_out, bus.a_out, bus.alu_out,
                  bus.mar_load, bus.ir_load, bus.a_load, bus.b_load, bus.ram_load,
                  bus.out_load, bus.pc_load, bus.flag_load, bus.pc_inc, bus.alu_sub};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // at most one bus driver per cycle
  always @(negedge clk) begin
    if (!done) begin
      compared++;
      if ($countones({bus.pc_out, bus.ir_out, bus.ram_out, bus.a_out, bus.alu_out}) > 1) begin
        mismatched++;
        $display("FAIL bus_rule: got enables %b required at most one",
                 {bus.pc_out, bus.ir_out, bus.ram_out, bus.a_out, bus.alu_out});
      end
    end
  end

  function automatic logic [W-1:0] mk(input logic h, input logic [2:0] s, input logic [14:0] st);
    return {h, s, st};
  endfunction

  function automatic vec_t mkv(input logic [3:0] opc, input logic c, input logic z, input int n,
                               input logic [14:0] s2, input logic [14:0] s3, input logic [14:0] s4);
    vec_t v;
    v.opc = opc; v.c = c; v.z = z; v.n = n; v.s2 = s2; v.s3 = s3; v.s4 = s4;
    return v;
  endfunction

  // driver: one cycle -- push expectation, compare at negedge, advance past next posedge
  task automatic cyc(input logic [W-1:0] e, input logic [1:0] st, input string nm);
    logic [W-1:0] ew;
    logic [1:0]   es;
    if (!manual_pulse) begin
`ifdef SAP_SEQ_SINGLE_STEP_EN
      bus.step_pulse = 1'b1;
`else
      bus.step_pulse = 1'($urandom_range(0, 1));
`endif
    end
    exp_q.push_back(e);
    exp_st_q.push_back(st);
    @(negedge clk);
    ew = exp_q.pop_front();
    es = exp_st_q.pop_front();
    compared++;
    if (act_w !== ew) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", nm, act_w, ew);
    end
    compared++;
    if (bus.dbg_state !== es) begin
      mismatched++;
      $display("FAIL %s_state: got %0d required %0d", nm, bus.dbg_state, es);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input vec_t v, input bit rnd_start);
    logic [14:0] s;
    bus.opcode     = v.opc;
    bus.carry_flag = v.c;
    bus.zero_flag  = v.z;
    for (int k = 0; k < v.n; k++) begin
      bus.start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      case (k)
        0: s = F0;
        1: s = F1;
        2: s = v.s2;
        3: s = v.s3;
        default: s = v.s4;
      endcase
      cyc(mk(1'b0, 3'(k), s), S_RUN, $sformatf("op%0h_c%0d_z%0d_t%0d", v.opc, v.c, v.z, k));
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    done           = 1'b0;
    manual_pulse   = 1'b0;
    reset          = 1'b0;
    bus.start      = 1'b1;
    bus.opcode     = 4'h0;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.step_pulse = 1'b0;

    tbl.push_back(mkv(4'h2, 0, 0, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAG_LD));
    tbl.push_back(mkv(4'h3, 1, 0, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAG_LD | ALU_SUB));
    tbl.push_back(mkv(4'h1, 0, 1, 4, IR_OUT | MAR_LD, RAM_OUT | A_LD, '0));
    tbl.push_back(mkv(4'h4, 1, 1, 4, IR_OUT | MAR_LD, A_OUT | RAM_LD, '0));
    tbl.push_back(mkv(4'h5, 0, 0, 3, IR_OUT | A_LD, '0, '0));
    tbl.push_back(mkv(4'h6, 0, 0, 3, IR_OUT | PC_LD, '0, '0));
    tbl.push_back(mkv(4'h7, 0, 1, 3, '0, '0, '0));
    tbl.push_back(mkv(4'h7, 1, 0, 3, IR_OUT | PC_LD, '0, '0));
    tbl.push_back(mkv(4'h8, 1, 0, 3, '0, '0, '0));
    tbl.push_back(mkv(4'h8, 0, 1, 3, IR_OUT | PC_LD, '0, '0));
    tbl.push_back(mkv(4'h0, 1, 1, 3, '0, '0, '0));
    tbl.push_back(mkv(4'hE, 0, 0, 3, A_OUT | OUT_LD, '0, '0));
    tbl.push_back(mkv(4'h9, 1, 1, 3, '0, '0, '0));
    tbl.push_back(mkv(4'hC, 0, 1, 3, '0, '0, '0));
    tbl.push_back(mkv(4'hD, 1, 0, 3, '0, '0, '0));
    tbl.push_back(mkv(4'h2, 1, 1, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | FLAG_LD));

    // reset held two edges with start high
    repeat (2) @(posedge clk);
    #1;
    cyc(mk(0, 0, '0), S_IDLE, "reset_hold");
    reset = 1'b1;
    bus.start = 1'b1;
    cyc(mk(0, 0, '0), S_IDLE, "idle_start");

    foreach (tbl[i]) run_instr(tbl[i], 1'b1);

    // halt, stay quiet, restart
    run_instr(mkv(4'hF, 1, 1, 3, '0, '0, '0), 1'b0);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) cyc(mk(1, 0, '0), S_HALT, $sformatf("halted_%0d", i));
    bus.start = 1'b1;
    cyc(mk(1, 0, '0), S_HALT, "halted_start");
    bus.start = 1'b0;

    // LDA interrupted by reset in T3
    bus.opcode = 4'h1;
    cyc(mk(0, 0, F0), S_RUN, "resume_t0");
    cyc(mk(0, 1, F1), S_RUN, "resume_t1");
    cyc(mk(0, 2, IR_OUT | MAR_LD), S_RUN, "lda_t2");
    reset = 1'b0;
    cyc(mk(0, 3, RAM_OUT | A_LD), S_RUN, "lda_t3_reset");
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, '0), S_IDLE, $sformatf("after_reset_%0d", i));
    reset = 1'b1;
    bus.start = 1'b0;
    cyc(mk(0, 0, '0), S_IDLE, "idle_no_start");

`ifdef SAP_SEQ_SINGLE_STEP_EN
    // LDI with step_pulse on every 4th cycle
    bus.opcode = 4'h5;
    bus.start = 1'b1;
    cyc(mk(0, 0, '0), S_IDLE, "ss_start");
    bus.start = 1'b0;
    manual_pulse = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic        p;
      logic [14:0] s;
      p = ((k % 4) == 3);
      bus.step_pulse = p;
      case (k / 4)
        0: s = PC_OUT | (p ? MAR_LD : 15'h0);
        1: s = RAM_OUT | (p ? (IR_LD | PC_INC) : 15'h0);
        default: s = IR_OUT | (p ? A_LD : 15'h0);
      endcase
      cyc(mk(0, 3'(k / 4), s), S_RUN, $sformatf("ss_ldi_%0d", k));
    end
    bus.step_pulse = 1'b0;
    cyc(mk(0, 0, PC_OUT), S_RUN, "ss_wrap_t0");
    manual_pulse = 1'b0;
`endif

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
